mem_stream_reader: RTL

MEM_STREAM_READER -- requirements
Module: mem_stream_reader

---
 rtl/mem_stream_reader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_stream_reader.sv
// Strided memory reader streaming words through a 2-entry output FIFO with valid/ready handshake.
// Optional stall counter enabled by defining MEM_STREAM_READER_STALL_CNT_EN.
module mem_stream_reader #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 64,
  parameter int unsigned LW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] length,
  input  logic [AW-1:0] stride,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_word,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic [15:0]   stall_cnt
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]    state_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] stride_q;
  logic [LW-1:0] rd_left_q;
  logic [LW-1:0] out_left_q;
  logic          inflight_q;
  logic          done_q;
  logic [DW-1:0] fifo_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;

  logic          accept;
  logic          issue_idle;
  logic          issue_run;
  logic          pop;
  logic [2:0]    occ;
  logic          room;

  always_comb begin
    accept     = rst_n && (state_q == StIdle) && start;
    // The first read goes out in the start cycle so data is buffered two cycles after start.
    issue_idle = accept && (length != '0);
    o_valid    = rst_n && (count_q != 2'd0);
    pop        = o_valid && o_ready;
    occ        = {1'b0, count_q} + {2'b00, inflight_q};
    room       = occ < (pop ? 3'd3 : 3'd2);
    issue_run  = rst_n && (state_q == StRun) && (rd_left_q != '0) && room;
    mem_rd_en  = issue_idle || issue_run;
    mem_rd_addr = '0;
    if (issue_idle) begin
      mem_rd_addr = base_addr;
    end else if (issue_run) begin
      mem_rd_addr = addr_q;
    end
    o_data = o_valid ? fifo_q[rd_ptr_q] : '0;
    busy   = rst_n && (state_q != StIdle);
    done   = rst_n && done_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      stride_q   <= '0;
      rd_left_q  <= '0;
      out_left_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= mem_rd_en;
      if (pop) begin
        out_left_q <= out_left_q - LW'(1);
        rd_ptr_q   <= ~rd_ptr_q;
      end
      if (inflight_q) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
      case (state_q)
        StIdle: begin
          if (accept) begin
            stride_q   <= stride;
            addr_q     <= base_addr + stride;
            rd_left_q  <= length - LW'(1);
            out_left_q <= length;
            if (length == '0) begin
              done_q <= 1'b1;
            end else if (length == LW'(1)) begin
              state_q <= StDrain;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (issue_run) begin
            addr_q    <= addr_q + stride_q;
            rd_left_q <= rd_left_q - LW'(1);
            if (rd_left_q == LW'(1)) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (pop && (out_left_q == LW'(1))) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (rst_n && inflight_q) begin
      fifo_q[wr_ptr_q] <= mem_rd_word;
    end
  end

`ifdef MEM_STREAM_READER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (o_valid && !o_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = rst_n ? stall_q : '0;
`else
  assign stall_cnt = '0;
`endif

endmodule
